// File: rtl/barrel_shifter_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR, one log2(WIDTH) stage per amount bit; latency AMT_W cycles, 1 beat/cycle.
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage and drops in_ready in the same cycle.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2");
  end

  // sign is the operand MSB taken at the input so SRA fill never depends on intermediate data
  typedef struct packed {
    logic             vld;
    logic             sign;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t stage_q [AMT_W];
  stage_t stage_d [AMT_W];
  logic   stall;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       mode,
                                                input logic             sign,
                                                input int               k);
    int sh;
    sh = 1 << k;
    case (mode)
      3'b000:  shift_by = d << sh;
      3'b001:  shift_by = d >> sh;
      3'b010:  shift_by = (d >> sh) | (sign ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}});
      3'b011:  shift_by = (d << sh) | (d >> (WIDTH - sh));
      3'b100:  shift_by = (d >> sh) | (d << (WIDTH - sh));
      default: shift_by = d;
    endcase
  endfunction

  assign stall     = stage_q[AMT_W-1].vld & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = stage_q[AMT_W-1].vld;
  assign out_data  = stage_q[AMT_W-1].dat;

  always_comb begin
    for (int k = 0; k < AMT_W; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (!stall) begin
      stage_d[0].vld  = in_valid;
      stage_d[0].sign = in_data[WIDTH-1];
      stage_d[0].mode = in_mode;
      stage_d[0].amt  = in_amt;
      stage_d[0].dat  = in_amt[0] ? shift_by(in_data, in_mode, in_data[WIDTH-1], 0) : in_data;
      for (int k = 1; k < AMT_W; k++) begin
        stage_d[k] = stage_q[k-1];
        if (stage_q[k-1].amt[k]) begin
          stage_d[k].dat = shift_by(stage_q[k-1].dat, stage_q[k-1].mode, stage_q[k-1].sign, k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < AMT_W; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < AMT_W; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for an 8-bit and a 32-bit barrel_shifter_pipe sharing clock and reset.
// Expected results come from a width-generic behavioural model, queued at accept and checked at transfer.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_out_data;
  logic [2:0]  a_in_amt, a_in_mode;

  logic        b_in_valid, b_in_ready, b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_amt;
  logic [2:0]  b_in_mode;

  barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_amt(a_in_amt), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_amt(b_in_amt), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    int          st;
  } sb_t;

  sb_t  a_q[$];
  sb_t  b_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   waits = 0;
  int   a_stall = 0, b_stall = 0;
  int   a_nout = 0, a_first = 0, a_last = 0;
  logic a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  logic [31:0] a_prev_dat = '0, b_prev_dat = '0;
  bit   b_rnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int a,
                                        input logic [2:0] m, input int w);
    logic [31:0] mask, r;
    logic        s;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    d = d & mask;
    s = d[w-1];
    case (m)
      3'd0:    r = d << a;
      3'd1:    r = d >> a;
      3'd2:    r = (d >> a) | (s ? (mask & ~(mask >> a)) : 32'h0);
      3'd3:    r = (d << a) | (d >> (w - a));
      3'd4:    r = (d >> a) | (d << (w - a));
      default: r = d;
    endcase
    return r & mask;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    b_out_ready = b_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      a_q.delete();
      a_prev_stall = 1'b0;
    end else begin
      if (a_in_valid && a_in_ready)
        a_q.push_back('{model(32'(a_in_data), int'(a_in_amt), a_in_mode, 8), cyc, a_stall});
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          chk("a_unexpected_beat", 32'(a_out_data), 32'hDEAD_BEEF);
        end else begin
          e = a_q.pop_front();
          chk("a_data", 32'(a_out_data), e.exp);
          chk("a_latency", 32'(cyc - e.cyc), 32'(3 + a_stall - e.st));
        end
        if (a_nout == 0) a_first = cyc;
        a_last = cyc;
        a_nout++;
      end
      if (a_out_valid && !a_out_ready) begin
        if (a_prev_stall) chk("a_stall_stable", 32'(a_out_data), a_prev_dat);
        a_stall++;
      end
      a_prev_stall = a_out_valid && !a_out_ready;
      a_prev_dat   = 32'(a_out_data);
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      b_q.delete();
      b_prev_stall = 1'b0;
    end else begin
      if (b_in_valid && b_in_ready)
        b_q.push_back('{model(b_in_data, int'(b_in_amt), b_in_mode, 32), cyc, b_stall});
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          chk("b_unexpected_beat", b_out_data, 32'hDEAD_BEEF);
        end else begin
          e = b_q.pop_front();
          chk("b_data", b_out_data, e.exp);
          chk("b_latency", 32'(cyc - e.cyc), 32'(5 + b_stall - e.st));
        end
      end
      if (b_out_valid && !b_out_ready) begin
        if (b_prev_stall) chk("b_stall_stable", b_out_data, b_prev_dat);
        b_stall++;
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      b_prev_dat   = b_out_data;
    end
  end

  task automatic a_send(input logic [7:0] d, input logic [2:0] amt, input logic [2:0] mode);
    bit ok;
    int n;
    n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_amt = amt; a_in_mode = mode;
    do begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok) waits++;
    end while (!ok && n < 50);
    if (!ok) chk("a_send_timeout", 32'(ok), 32'h1);
  endtask

  task automatic b_send(input logic [31:0] d, input logic [4:0] amt, input logic [2:0] mode);
    bit ok;
    int n;
    n = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_amt = amt; b_in_mode = mode;
    do begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("b_send_timeout", 32'(ok), 32'h1);
  endtask

  task automatic a_drain();
    int n;
    n = 0;
    a_in_valid = 1'b0;
    while (a_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("a_drain_left", 32'(a_q.size()), 32'h0);
  endtask

  task automatic b_drain();
    int n;
    n = 0;
    b_in_valid = 1'b0;
    while (b_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("b_drain_left", 32'(b_q.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_a_out_data",  32'(a_out_data),  32'h0);
    chk("rst_a_in_ready",  32'(a_in_ready),  32'h1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'h0);
    chk("rst_b_in_ready",  32'(b_in_ready),  32'h1);
    @(posedge clk); #1;

    // every mode on one operand, amt=3
    for (int m = 0; m < 5; m++) a_send(8'b1101_0111, 3'd3, 3'(m));
    a_drain();

    // boundary amounts, amt=0 on all modes, reserved modes
    a_send(8'h01, 3'd7, 3'd3);
    a_send(8'h80, 3'd7, 3'd1);
    a_send(8'h80, 3'd7, 3'd2);
    a_send(8'h7F, 3'd7, 3'd2);
    a_send(8'h80, 3'd7, 3'd0);
    a_send(8'h01, 3'd7, 3'd4);
    for (int m = 0; m < 8; m++) a_send(8'hA5, 3'd0, 3'(m));
    a_send(8'h96, 3'd5, 3'd7);
    a_send(8'h3C, 3'd6, 3'd6);
    a_send(8'hC3, 3'd2, 3'd5);
    a_drain();

    // 16 back-to-back beats with the consumer always ready
    waits = 0;
    a_nout = 0;
    for (int i = 0; i < 16; i++) a_send(8'hB4 ^ 8'(i * 17), 3'(i % 8), (i < 8) ? 3'd0 : 3'd4);
    a_drain();
    chk("stream_in_ready_waits", 32'(waits), 32'h0);
    chk("stream_count", 32'(a_nout), 32'd16);
    chk("stream_span", 32'(a_last - a_first), 32'd15);

    // consumer stalls for 3 cycles while the pipe is full
    a_nout = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) a_send(8'h11 * 8'(i + 1), 3'(i + 1), 3'(i % 5));
        a_in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_out", 32'(a_out_valid), 32'h1);
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(a_in_ready), 32'h0);
          chk("bp_out_valid", 32'(a_out_valid), 32'h1);
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
      end
    join
    a_drain();
    chk("bp_count", 32'(a_nout), 32'd6);

    // reset with beats in flight and in_valid high during the reset cycle
    for (int i = 0; i < 3; i++) a_send(8'hF0 + 8'(i), 3'd1, 3'd0);
    reset = 1'b1;
    a_in_data = 8'h5A;
    @(posedge clk); #1;
    reset = 1'b0;
    a_in_valid = 1'b0;
    a_nout = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(a_out_valid), 32'h0);
    chk("midrst_out_data",  32'(a_out_data),  32'h0);
    chk("midrst_in_ready",  32'(a_in_ready),  32'h1);
    repeat (5) @(negedge clk);
    chk("midrst_no_stale", 32'(a_nout), 32'h0);
    @(posedge clk); #1;

    // 32-bit instance: directed corners, then random beats with random backpressure
    b_send(32'h8000_0001, 5'd31, 3'd4);
    b_send(32'h8000_0000, 5'd31, 3'd2);
    b_send(32'h0000_0001, 5'd31, 3'd3);
    b_send(32'h7FFF_FFFF, 5'd31, 3'd2);
    b_drain();
    b_rnd = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        b_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      b_send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
    end
    b_drain();
    b_rnd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
